modn_bcd_counter: RTL and testbench
===================================

Name: modn_bcd_counter

Overview:
- Parametrised modulo-N time-digit counter; successor to the fixed 0–23 hour counter.
- Runs on the single system clock and advances on a count-enable tick instead of a derived slow clock.
- Adds synchronous load, manual up/down adjust, carry-out for cascading (sec→min→hour) and an optional 12 h display mode.
- A serial double-dabble FSM converts the display value to N BCD digits, and a valid flag qualifies the result for the 7-segment decoders.

Parameters:
- MODULO, 24, count wraps MODULO-1 → 0; must be ≥ 2.
- CW, 5, counter width in bits; must satisfy 2^CW ≥ MODULO.
- ND, 2, BCD output digits; must satisfy 10^ND > MODULO-1.
- H12_EN, 1, enables 12 h display mode; ignored unless MODULO == 24.

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  reset, synchronous, active-low.
- ival_i  in  CW  value loaded at reset and on load_i.
- load_i  in  1  synchronous load of ival_i.
- tick_i  in  1  count enable; one increment per cycle high.
- adj_up_i  in  1  manual +1, no carry.
- adj_dn_i  in  1  manual −1, no borrow.
- mode12_i  in  1  1 = 12 h display (only when H12_EN and MODULO == 24).
- count_o  out  CW  registered binary count.
- carry_o  out  1  one-cycle pulse on tick-driven wrap.
- pm_o  out  1  registered; 1 when count ≥ 12 (0 when 12 h mode is inactive).
- bcd_o  out  4*ND  display value as BCD; digit 0 in [3:0].
- bcd_valid_o  out  1  bcd_o matches the current count/mode.

Behaviour:
- Reset (rst_ni = 0 at a clk_i edge):
  - count_o = ival_i, or 0 if ival_i ≥ MODULO.
  - carry_o = 0, pm_o per the loaded count, bcd_o = 0, bcd_valid_o = 0, FSM = IDLE with a forced conversion pending.
  - Reset mid-conversion aborts the conversion.
- Count update priority, one action per cycle:
  1. load_i: count = ival_i, or 0 if ival_i ≥ MODULO.
  2. adj_up_i XOR adj_dn_i: ±1 modulo MODULO (0 − 1 → MODULO-1). Both high = no change.
  3. tick_i: count = count == MODULO-1 ? 0 : count+1.
  - A tick coincident with load or adjust is dropped.
- carry_o is 1 in the cycle after an edge where tick_i caused the MODULO-1 → 0 wrap. Load and adjust never raise carry_o.
- Display value dv:
  - 24 h / generic mode: dv = count.
  - 12 h mode: dv = count mod 12, with 0 mapped to 12.
- Conversion FSM states IDLE → SHIFT → DONE → IDLE:
  - IDLE: when dv differs from the last converted value, mode12_i changed, or a forced conversion is pending → snapshot dv, clear bcd_valid_o, go to SHIFT.
  - SHIFT: CW iterations. Each iteration adds 3 to every BCD digit ≥ 5, then shifts left 1, MSB of dv first.
  - DONE: write bcd_o, set bcd_valid_o = 1, record the converted value, go to IDLE.
  - If dv changes while in SHIFT, finish the current conversion. IDLE then immediately restarts, so bcd_valid_o stays low.
- Latency:
  - count changes at edge N.
  - bcd_valid_o = 0 from edge N+1.
  - New bcd_o and bcd_valid_o = 1 at edge N+CW+2.
  - The previous bcd_o is held, stale, until then.
- Widths: all count arithmetic is done in CW+1 bits and compared against MODULO before truncation, so no silent overflow at 2^CW.

Decomposition:
- Package modn_count_pkg:
  - conv_state_t enum (IDLE, SHIFT, DONE).
  - Constant H12_BASE = 12.
  - Function for the conversion iteration counter width, clog2(CW+1).
- Sub-module bcd_dd_conv (params CW, ND):
  - Ports start_i, bin_i, busy_o, done_o, bcd_o.
  - Holds the FSM and shift register.
  - The top level keeps the counter, priority logic, 12 h mapping and change detection.

Test Plan:
- Reset with ival_i = 22, then 3 ticks → count 23 → 0 → 1. carry_o pulses once, on the 23→0 step. After settling, bcd_o = 0x01 with bcd_valid_o = 1 exactly CW+2 cycles after the last count edge.
- Reset with ival_i = 30 (≥ MODULO) → count_o = 0, bcd_o = 0x00 after conversion.
- mode12_i = 1, count swept 0..23 by ticks → bcd_o runs 0x12, 0x01..0x11, 0x12, 0x01..0x11. pm_o = 0 for count 0..11 and 1 for count 12..23.
- count = 0, adj_dn_i pulse → count 23, no carry_o. adj_up_i and adj_dn_i high together → no change. load_i, adj_up_i and tick_i together → count = ival_i.
- Tick every cycle for 30 cycles → bcd_valid_o stays 0. Stop ticking → bcd_o equals final count in BCD and valid rises CW+2 cycles later.
- rst_ni = 0 during SHIFT → next cycle bcd_valid_o = 0 and bcd_o = 0. Conversion of ival_i completes CW+2 cycles after rst_ni releases.

Source files
------------

// File: rtl/modn_count_pkg.sv
// Shared types and constants for the modulo-N BCD time-digit counter.
//   conv_state_t : states of the serial double-dabble converter
//   H12_BASE     : modulus of the 12 h display mapping
//   iter_cnt_w() : width of the converter iteration counter for a CW-bit input
package modn_count_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } conv_state_t;

  localparam int unsigned H12_BASE = 12;

  function automatic int unsigned iter_cnt_w(input int unsigned cw);
    return (cw + 1 <= 2) ? 1 : $clog2(cw + 1);
  endfunction

endpackage

// File: rtl/bcd_dd_conv.sv
// Serial double-dabble binary-to-BCD converter.
//   clk_i, rst_ni : system clock, synchronous active-low reset
//   start_i       : sampled in IDLE; snapshots bin_i and starts a conversion
//   bin_i  [CW]   : binary value to convert
//   busy_o        : converter is not in IDLE
//   done_o        : converter is in DONE; bcd_o is written at the end of this cycle
//   bcd_o [4*ND]  : registered BCD result, digit 0 in [3:0]
module bcd_dd_conv
  import modn_count_pkg::*;
#(
  parameter int unsigned CW = 5,
  parameter int unsigned ND = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [CW-1:0]     bin_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [4*ND-1:0]   bcd_o
);

  localparam int unsigned IW = iter_cnt_w(CW);
  localparam int unsigned SW = 4 * ND + CW;

  conv_state_t   state_q, state_d;
  logic [SW-1:0] sr_q;
  logic [SW-1:0] sr_adj;
  logic [SW-1:0] sr_step;
  logic [IW-1:0] iter_q;

  // Shift register layout: {BCD digits, remaining binary bits}; the binary
  // MSB is shifted into the lowest BCD digit on every iteration.
  always_comb begin
    sr_adj = sr_q;
    for (int unsigned d = 0; d < ND; d++) begin
      if (sr_adj[CW + 4*d +: 4] >= 4'd5) begin
        sr_adj[CW + 4*d +: 4] = sr_adj[CW + 4*d +: 4] + 4'd3;
      end
    end
    sr_step = sr_adj << 1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = SHIFT;
      SHIFT:   if (iter_q == IW'(CW - 1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      sr_q    <= '0;
      iter_q  <= '0;
      bcd_o   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            sr_q   <= {{(4*ND){1'b0}}, bin_i};
            iter_q <= '0;
          end
        end
        SHIFT: begin
          sr_q   <= sr_step;
          iter_q <= iter_q + IW'(1);
        end
        DONE:    bcd_o <= sr_q[SW-1:CW];
        default: ;
      endcase
    end
  end

  assign busy_o = (state_q != IDLE);
  assign done_o = (state_q == DONE);

endmodule

// File: rtl/modn_bcd_counter.sv
// Modulo-N time-digit counter with load, manual adjust, carry-out for
// cascading, optional 12 h display mapping and a serial BCD display output.
//   clk_i, rst_ni      : system clock, synchronous active-low reset
//   ival_i   [CW]      : value loaded at reset and on load_i (>= MODULO loads 0)
//   load_i             : synchronous load (highest priority)
//   adj_up_i/adj_dn_i  : manual +1 / -1 with wrap, no carry; both high = hold
//   tick_i             : count enable, dropped when load or adjust is active
//   mode12_i           : 12 h display (only when H12_EN and MODULO == 24)
//   count_o  [CW]      : registered binary count
//   carry_o            : one-cycle pulse after a tick-driven wrap to 0
//   pm_o               : registered, count >= 12 in 12 h mode
//   bcd_o    [4*ND]    : display value in BCD, digit 0 in [3:0]
//   bcd_valid_o        : bcd_o reflects the current count/mode
module modn_bcd_counter
  import modn_count_pkg::*;
#(
  parameter int unsigned MODULO = 24,
  parameter int unsigned CW     = 5,
  parameter int unsigned ND     = 2,
  parameter bit          H12_EN = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [CW-1:0]     ival_i,
  input  logic              load_i,
  input  logic              tick_i,
  input  logic              adj_up_i,
  input  logic              adj_dn_i,
  input  logic              mode12_i,
  output logic [CW-1:0]     count_o,
  output logic              carry_o,
  output logic              pm_o,
  output logic [4*ND-1:0]   bcd_o,
  output logic              bcd_valid_o
);

  localparam bit            H12_OK = H12_EN && (MODULO == 24);
  localparam logic [CW:0]   MOD_W  = (CW+1)'(MODULO);
  localparam logic [CW-1:0] MAX_C  = CW'(MODULO - 1);
  localparam logic [CW-1:0] H12_C  = CW'(H12_BASE);

  logic [CW:0]   ival_w, inc_w;
  logic [CW-1:0] ld_val, cnt_d, hr, dv;
  logic [CW-1:0] snap_dv, last_dv;
  logic          carry_d, pm_d, mode_eff;
  logic          snap_mode, last_mode, force_q;
  logic          start, busy, done;

  // Range checks are done one bit wider so 2^CW never aliases onto 0.
  assign ival_w = {1'b0, ival_i};
  assign inc_w  = {1'b0, count_o} + (CW+1)'(1);
  assign ld_val = (ival_w < MOD_W) ? ival_i : '0;

  always_comb begin
    cnt_d   = count_o;
    carry_d = 1'b0;
    if (load_i) begin
      cnt_d = ld_val;
    end else if (adj_up_i || adj_dn_i) begin
      if (adj_up_i && !adj_dn_i) begin
        cnt_d = (inc_w == MOD_W) ? '0 : inc_w[CW-1:0];
      end else if (adj_dn_i && !adj_up_i) begin
        cnt_d = (count_o == '0) ? MAX_C : count_o - CW'(1);
      end
    end else if (tick_i) begin
      cnt_d   = (inc_w == MOD_W) ? '0 : inc_w[CW-1:0];
      carry_d = (inc_w == MOD_W);
    end
  end

  assign mode_eff = H12_OK && mode12_i;
  assign pm_d     = mode_eff && (cnt_d >= H12_C);
  assign hr       = (count_o >= H12_C) ? count_o - H12_C : count_o;
  assign dv       = mode_eff ? ((hr == '0) ? H12_C : hr) : count_o;

  assign start = !busy && (force_q || (dv != last_dv) || (mode_eff != last_mode));

  // On completion the result is only flagged valid if the display value did
  // not move while converting; otherwise IDLE restarts on the next cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_o     <= ld_val;
      carry_o     <= 1'b0;
      pm_o        <= mode_eff && (ld_val >= H12_C);
      bcd_valid_o <= 1'b0;
      force_q     <= 1'b1;
      last_dv     <= '0;
      last_mode   <= 1'b0;
      snap_dv     <= '0;
      snap_mode   <= 1'b0;
    end else begin
      count_o <= cnt_d;
      carry_o <= carry_d;
      pm_o    <= pm_d;
      if (start) begin
        bcd_valid_o <= 1'b0;
        force_q     <= 1'b0;
        snap_dv     <= dv;
        snap_mode   <= mode_eff;
      end else if (done) begin
        bcd_valid_o <= (dv == snap_dv) && (mode_eff == snap_mode);
        last_dv     <= snap_dv;
        last_mode   <= snap_mode;
      end
    end
  end

  bcd_dd_conv #(
    .CW (CW),
    .ND (ND)
  ) u_conv (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .start_i (start),
    .bin_i   (dv),
    .busy_o  (busy),
    .done_o  (done),
    .bcd_o   (bcd_o)
  );

endmodule

// File: tb/tb_modn_bcd_counter.sv
// Self-checking bench for modn_bcd_counter (MODULO=24, CW=5, ND=2, 12 h enabled).
module tb_modn_bcd_counter;

  localparam int CW = 5;
  localparam int ND = 2;

  logic            clk = 1'b0;
  logic            rst_ni = 1'b1;
  logic [CW-1:0]   ival = '0;
  logic            load = 1'b0, tick = 1'b0, up = 1'b0, dn = 1'b0, m12 = 1'b0;
  logic [CW-1:0]   count;
  logic            carry, pm, valid;
  logic [4*ND-1:0] bcd;

  int total = 0;
  int bad = 0;
  int extra_carry = 0;

  // reference model state
  int mc;
  int mcy;
  int mpm;

  typedef struct {
    bit ld; int iv; bit u; bit d; bit tk; bit md;
    int cnt; bit cy; bit p;
  } vec_t;
  vec_t tbl[16];

  modn_bcd_counter #(
    .MODULO (24),
    .CW     (CW),
    .ND     (ND),
    .H12_EN (1'b1)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .ival_i      (ival),
    .load_i      (load),
    .tick_i      (tick),
    .adj_up_i    (up),
    .adj_dn_i    (dn),
    .mode12_i    (m12),
    .count_o     (count),
    .carry_o     (carry),
    .pm_o        (pm),
    .bcd_o       (bcd),
    .bcd_valid_o (valid)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int disp(input int c, input bit md);
    int r;
    if (!md) return c;
    r = c % 12;
    return (r == 0) ? 12 : r;
  endfunction

  function automatic int to_bcd(input int v);
    return (v / 10) * 16 + (v % 10);
  endfunction

  // Spec-level count rules applied to the inputs present at an edge.
  task automatic model_edge();
    mcy = 0;
    if (load) mc = (int'(ival) < 24) ? int'(ival) : 0;
    else if (up && !dn) mc = (mc + 1) % 24;
    else if (dn && !up) mc = (mc + 23) % 24;
    else if (up && dn) mc = mc;
    else if (tick) begin
      mcy = (mc == 23) ? 1 : 0;
      mc  = (mc + 1) % 24;
    end
    mpm = (m12 && mc >= 12) ? 1 : 0;
  endtask

  task automatic idle_inputs();
    load = 1'b0; tick = 1'b0; up = 1'b0; dn = 1'b0;
  endtask

  task automatic do_reset(input int v);
    idle_inputs();
    ival   = CW'(v);
    rst_ni = 1'b0;
    step();
    rst_ni = 1'b1;
  endtask

  // After a count change at the last sampled edge: valid low for CW+1 edges,
  // then high with the expected BCD on the next.
  task automatic check_conv(input string name, input int exp);
    int lowbad = 0;
    for (int i = 1; i <= CW + 1; i++) begin
      step();
      if (valid !== 1'b0) lowbad++;
      if (carry) extra_carry++;
    end
    chk({name, "_low"}, lowbad, 0);
    step();
    if (carry) extra_carry++;
    chk({name, "_valid"}, int'(valid), 1);
    chk({name, "_bcd"}, int'(bcd), exp);
  endtask

  task automatic wait_valid(input int budget, output int n);
    n = 0;
    while (valid !== 1'b1 && n < budget) begin
      step();
      n++;
    end
  endtask

  initial begin
    int n;
    int lowbad;
    int prev_key, key;
    string nm;

    //            ld iv  u  d  tk md  cnt cy p
    tbl[0]  = '{0, 0,  0, 1, 0, 0,  0, 0, 0};
    tbl[1]  = '{0, 0,  0, 1, 0, 0, 23, 0, 0};
    tbl[2]  = '{0, 0,  1, 1, 0, 0, 23, 0, 0};
    tbl[3]  = '{0, 0,  1, 0, 0, 0,  0, 0, 0};
    tbl[4]  = '{0, 0,  0, 0, 1, 0,  1, 0, 0};
    tbl[5]  = '{1, 22, 0, 0, 0, 0, 22, 0, 0};
    tbl[6]  = '{0, 0,  0, 0, 1, 0, 23, 0, 0};
    tbl[7]  = '{0, 0,  0, 0, 1, 0,  0, 1, 0};
    tbl[8]  = '{1, 7,  1, 0, 1, 0,  7, 0, 0};
    tbl[9]  = '{1, 30, 0, 0, 0, 0,  0, 0, 0};
    tbl[10] = '{1, 13, 0, 0, 0, 1, 13, 0, 1};
    tbl[11] = '{0, 0,  0, 0, 1, 1, 14, 0, 1};
    tbl[12] = '{1, 11, 0, 0, 0, 1, 11, 0, 0};
    tbl[13] = '{0, 0,  0, 0, 1, 0, 12, 0, 0};
    tbl[14] = '{1, 23, 0, 0, 1, 0, 23, 0, 0};
    tbl[15] = '{0, 0,  0, 1, 1, 0, 22, 0, 0};

    // A: reset to 22, spaced ticks through the wrap
    m12 = 1'b0;
    do_reset(22);
    chk("a_rst_count", int'(count), 22);
    chk("a_rst_carry", int'(carry), 0);
    chk("a_rst_valid", int'(valid), 0);
    chk("a_rst_bcd", int'(bcd), 0);
    check_conv("a_conv22", 'h22);
    tick = 1'b1; step(); tick = 1'b0;
    chk("a_cnt23", int'(count), 23);
    chk("a_carry23", int'(carry), 0);
    check_conv("a_conv23", 'h23);
    tick = 1'b1; step(); tick = 1'b0;
    chk("a_cnt0", int'(count), 0);
    chk("a_carry_wrap", int'(carry), 1);
    check_conv("a_conv0", 'h00);
    tick = 1'b1; step(); tick = 1'b0;
    chk("a_cnt1", int'(count), 1);
    chk("a_carry1", int'(carry), 0);
    check_conv("a_conv1", 'h01);
    chk("a_single_carry", extra_carry, 0);

    // Table: priority, adjust wrap, load range, pm
    for (int i = 0; i < 16; i++) begin
      load = tbl[i].ld; ival = CW'(tbl[i].iv); up = tbl[i].u; dn = tbl[i].d;
      tick = tbl[i].tk; m12 = tbl[i].md;
      step();
      idle_inputs();
      chk($sformatf("tbl%0d_count", i), int'(count), tbl[i].cnt);
      chk($sformatf("tbl%0d_carry", i), int'(carry), int'(tbl[i].cy));
      chk($sformatf("tbl%0d_pm", i), int'(pm), int'(tbl[i].p));
    end

    // B: out-of-range reset value
    m12 = 1'b0;
    do_reset(30);
    chk("b_rst_count", int'(count), 0);
    check_conv("b_conv", 'h00);

    // C: 12 h sweep
    m12 = 1'b1; load = 1'b1; ival = '0;
    step();
    idle_inputs();
    step();
    wait_valid(40, n);
    chk("c_valid0", int'(valid), 1);
    chk("c_bcd0", int'(bcd), 'h12);
    chk("c_pm0", int'(pm), 0);
    for (int c = 1; c <= 24; c++) begin
      tick = 1'b1; step(); tick = 1'b0;
      nm = $sformatf("c_%0d", c % 24);
      chk({nm, "_pm"}, int'(pm), ((c % 24) >= 12) ? 1 : 0);
      check_conv(nm, to_bcd(disp(c % 24, 1'b1)));
    end

    // D: continuous ticking keeps valid low
    m12 = 1'b0; mc = 0;
    lowbad = 0;
    tick = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step();
      mc = (mc + 1) % 24;
      if (valid !== 1'b0) lowbad++;
    end
    tick = 1'b0;
    chk("d_valid_low", lowbad, 0);
    chk("d_count", int'(count), mc);
    wait_valid(2 * CW + 8, n);
    chk("d_valid_rise", int'(valid), 1);
    chk("d_latency_min", (n >= CW + 2) ? 1 : 0, 1);
    chk("d_bcd", int'(bcd), to_bcd(mc));

    // E: reset while converting
    tick = 1'b1; step(); tick = 1'b0;
    step(); step(); step();
    do_reset(5);
    chk("e_valid", int'(valid), 0);
    chk("e_bcd", int'(bcd), 0);
    chk("e_count", int'(count), 5);
    check_conv("e_conv", 'h05);

    // Random phase against the model
    mc = 5; m12 = 1'b0;
    prev_key = disp(mc, 1'b0);
    for (int i = 0; i < 600; i++) begin
      int r;
      idle_inputs();
      load = ($urandom_range(0, 15) == 0);
      ival = CW'($urandom_range(0, 31));
      r = $urandom_range(0, 19);
      up = (r == 0);
      dn = (r == 1);
      tick = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 49) == 0) m12 = ~m12;
      model_edge();
      step();
      chk("r_count", int'(count), mc);
      chk("r_carry", int'(carry), mcy);
      chk("r_pm", int'(pm), mpm);
      key = (m12 ? 100 : 0) + disp(mc, m12);
      if (valid === 1'b1 && key == prev_key)
        chk("r_bcd", int'(bcd), to_bcd(disp(mc, m12)));
      prev_key = key;
    end
    idle_inputs();
    step();
    wait_valid(2 * CW + 8, n);
    chk("r_final_valid", int'(valid), 1);
    chk("r_final_bcd", int'(bcd), to_bcd(disp(mc, m12)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
